// File: rtl/ram2_pkg.sv
// ram2_pkg -- shared definitions for the RAM2 instruction-memory controller.
//   state_t / ST_*  : controller FSM state encoding
//   ADDR_W_DEF      : default SRAM chip address width
//   WE_CYCLES_DEF   : default write-enable pulse length in pci_clk cycles
//   NOP_WORD        : instruction word the fetch stage treats as a no-op
package ram2_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WSETUP = 2'd1;
  localparam state_t ST_WPULSE = 2'd2;
  localparam state_t ST_WHOLD  = 2'd3;

  localparam int ADDR_W_DEF    = 18;
  localparam int WE_CYCLES_DEF = 2;

  localparam logic [15:0] NOP_WORD = 16'h0800;

endpackage

// File: rtl/ram2_wr_timer.sv
// ram2_wr_timer -- times the SRAM write-enable pulse.
//   pci_clk : clock, rising edge
//   pci_rst : asynchronous active-low reset
//   load    : restart the count (asserted during write setup)
//   count   : advance one step per cycle (asserted while we_n is low)
//   done    : the current cycle is the last of CYCLES pulse cycles
module ram2_wr_timer
  import ram2_pkg::*;
#(
  parameter int CYCLES = WE_CYCLES_DEF
) (
  input  logic pci_clk,
  input  logic pci_rst,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam logic [2:0] LAST = 3'(CYCLES - 1);

  logic [2:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge pci_clk or negedge pci_rst) begin
    if (!pci_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !done) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/ram2_ctrl.sv
// ram2_ctrl -- instruction fetch and store controller for the RAM2 SRAM.
// Fetches read the asynchronous SRAM continuously; a store stalls fetch
// and runs a setup / write-pulse / hold sequence on the SRAM strobes.
//   pci_clk, pci_rst         : clock, asynchronous active-low reset
//   fetch_addr / fetch_instr : fetch address in, registered word out
//   st_req, st_addr, st_data : store request (sampled in IDLE only)
//   st_busy                  : stall to fetch stage and store requester
//   ram2_addr, ram2_data     : SRAM address and bidirectional data bus
//   ram2_oe_n/we_n/en_n      : SRAM strobes, active-low
// Build option: define RAM2_WRITE_EN to include the store path; without
// it the controller is a read-only fetch port.
module ram2_ctrl
  import ram2_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WE_CYCLES = WE_CYCLES_DEF
) (
  input  logic              pci_clk,
  input  logic              pci_rst,
  input  logic [15:0]       fetch_addr,
  output logic [15:0]       fetch_instr,
  input  logic              st_req,
  input  logic [15:0]       st_addr,
  input  logic [15:0]       st_data,
  output logic              st_busy,
  output logic [ADDR_W-1:0] ram2_addr,
  inout  wire  [15:0]       ram2_data,
  output logic              ram2_oe_n,
  output logic              ram2_we_n,
  output logic              ram2_en_n
);

  logic bus_drive;   // controller owns ram2_data
  logic fetch_en;    // fetch_instr samples the bus this edge
  logic timer_load;
  logic timer_count;
  logic timer_done;

  // The chip stays selected; reads and writes are steered by oe_n/we_n.
  assign ram2_en_n = 1'b0;

  ram2_wr_timer #(.CYCLES(WE_CYCLES)) u_timer (
    .pci_clk (pci_clk),
    .pci_rst (pci_rst),
    .load    (timer_load),
    .count   (timer_count),
    .done    (timer_done)
  );

`ifdef RAM2_WRITE_EN
  state_t      state;
  state_t      state_nxt;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE:   if (st_req) state_nxt = ST_WSETUP;
      ST_WSETUP: state_nxt = ST_WPULSE;
      ST_WPULSE: if (timer_done) state_nxt = ST_WHOLD;
      ST_WHOLD:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pci_clk or negedge pci_rst) begin
    if (!pci_rst) begin
      state   <= ST_IDLE;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && st_req) begin
        wr_addr <= st_addr;
        wr_data <= st_data;
      end
    end
  end

  assign timer_load  = (state == ST_WSETUP);
  assign timer_count = (state == ST_WPULSE);

  // Busy rises combinationally with the request so the fetch stage stalls
  // in the capture cycle; reset forces it low even if st_req is held.
  assign st_busy   = pci_rst && ((state != ST_IDLE) || st_req);
  // A request in IDLE (including the back-to-back return cycle) takes the
  // edge for the store, so no fetch sample is taken then.
  assign fetch_en  = (state == ST_IDLE) && !st_req;

  // All strobes decode straight from state, so an asynchronous reset
  // raises we_n and releases the bus without waiting for a clock edge.
  // oe_n is high in every write state, keeping we_n/oe_n and bus
  // ownership mutually exclusive with the SRAM output.
  assign ram2_oe_n = (state != ST_IDLE);
  assign ram2_we_n = (state != ST_WPULSE);
  assign bus_drive = (state != ST_IDLE);
  assign ram2_addr = ADDR_W'((state == ST_IDLE) ? fetch_addr : wr_addr);
  assign ram2_data = bus_drive ? wr_data : 16'hzzzz;
`else
  logic unused_write_path;

  // Timer is parked so both builds share one hierarchy.
  assign timer_load        = 1'b1;
  assign timer_count       = 1'b0;
  assign unused_write_path = ^{st_req, st_addr, st_data, timer_done};

  assign st_busy   = 1'b0;
  assign fetch_en  = 1'b1;
  assign ram2_oe_n = 1'b0;
  assign ram2_we_n = 1'b1;
  assign bus_drive = 1'b0;
  assign ram2_addr = ADDR_W'(fetch_addr);
  assign ram2_data = 16'hzzzz;
`endif

  // The SRAM is asynchronous: data for fetch_addr is on the bus within the
  // cycle and is registered on the following edge.
  always_ff @(posedge pci_clk or negedge pci_rst) begin
    if (!pci_rst) begin
      fetch_instr <= '0;
    end else if (fetch_en) begin
      fetch_instr <= ram2_data;
    end
  end

endmodule

// File: tb/tb_ram2_ctrl.sv
// tb_ram2_ctrl -- self-checking bench for ram2_ctrl with an asynchronous
// SRAM model on the ram2_* pins and a word-level reference memory.
`timescale 1ns/1ps
module tb_ram2_ctrl;

  localparam int ADDR_W    = 18;
  localparam int WE_CYCLES = 2;

  logic              pci_clk = 1'b0;
  logic              pci_rst = 1'b0;
  logic [15:0]       fetch_addr;
  logic [15:0]       fetch_instr;
  logic              st_req;
  logic [15:0]       st_addr;
  logic [15:0]       st_data;
  logic              st_busy;
  logic [ADDR_W-1:0] ram2_addr;
  wire  [15:0]       ram2_data;
  logic              ram2_oe_n;
  logic              ram2_we_n;
  logic              ram2_en_n;

  int checks      = 0;
  int failures    = 0;
  int writes_done = 0;

  logic [15:0] mem     [0:65535];  // contents of the SRAM chip
  logic [15:0] ref_mem [0:65535];  // what software expects memory to hold

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp;
  } fetch_vec_t;

  ram2_ctrl #(.ADDR_W(ADDR_W), .WE_CYCLES(WE_CYCLES)) dut (
    .pci_clk     (pci_clk),
    .pci_rst     (pci_rst),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .st_req      (st_req),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_busy     (st_busy),
    .ram2_addr   (ram2_addr),
    .ram2_data   (ram2_data),
    .ram2_oe_n   (ram2_oe_n),
    .ram2_we_n   (ram2_we_n),
    .ram2_en_n   (ram2_en_n)
  );

  always #5 pci_clk = ~pci_clk;

  // Asynchronous SRAM: drives the bus while selected for read, writes on
  // the rising edge of we_n. A pulse cut short by reset is not a write.
  assign ram2_data = (!ram2_en_n && !ram2_oe_n && ram2_we_n) ?
                     mem[ram2_addr[15:0]] : 16'hzzzz;

  always @(posedge ram2_we_n) begin
    if (pci_rst === 1'b1 && ram2_en_n === 1'b0) begin
      mem[ram2_addr[15:0]] = ram2_data;
      writes_done++;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus-safety rules checked on every cycle out of reset.
  always @(negedge pci_clk) begin
    if (pci_rst) begin
      check("we_oe_exclusive", 32'(!ram2_we_n && !ram2_oe_n), 32'd0);
      check("bus_drive_oe", 32'(dut.bus_drive && !ram2_oe_n), 32'd0);
      check("addr_upper_zero", 32'(ram2_addr[ADDR_W-1:16]), 32'd0);
    end
  end

  task automatic tick();
    @(posedge pci_clk);
    @(negedge pci_clk);
  endtask

  task automatic fetch_check(input string name, input logic [15:0] addr);
    fetch_addr = addr;
    #1;
    check({name, "_addr"}, 32'(ram2_addr), 32'(addr));
    tick();
    check(name, 32'(fetch_instr), 32'(ref_mem[addr]));
  endtask

  // Issue n (1 or 2) stores with st_req held until the last is captured,
  // then compare busy length, pulse length and completed SRAM writes.
  task automatic store_burst(input string tag, input int n,
                             input logic [15:0] a0, input logic [15:0] d0,
                             input logic [15:0] a1, input logic [15:0] d1);
    int          busy_cyc = 0;
    int          we_low   = 0;
    int          idx      = 0;
    int          w0       = writes_done;
    logic [15:0] held     = fetch_instr;
    logic [15:0] cur_a    = a0;
    logic [15:0] cur_d    = d0;
    logic        capture;
    st_req  = 1'b1;
    st_addr = a0;
    st_data = d0;
    #1;
    while (st_busy && busy_cyc < 40) begin
      busy_cyc++;
      if (!ram2_we_n) begin
        we_low++;
        check({tag, "_pulse_addr"}, 32'(ram2_addr), 32'(cur_a));
        check({tag, "_pulse_data"}, 32'(ram2_data), 32'(cur_d));
      end
      capture = !ram2_oe_n;
      if (capture) begin
        cur_a = st_addr;
        cur_d = st_data;
      end
      tick();
      if (capture) begin
        idx++;
        if (idx < n) begin
          st_addr = a1;
          st_data = d1;
        end else begin
          st_req = 1'b0;
        end
      end
      #1;
    end
    st_req = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(n * (WE_CYCLES + 3)));
    check({tag, "_we_low_cycles"}, 32'(we_low), 32'(n * WE_CYCLES));
    check({tag, "_writes"}, 32'(writes_done - w0), 32'(n));
    check({tag, "_fetch_held"}, 32'(fetch_instr), 32'(held));
    ref_mem[a0] = d0;
    if (n > 1) ref_mem[a1] = d1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fetch_vec_t  vecs [4];
    logic [15:0] a;
    int          w0;
    int          budget;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i) ^ 16'h5A3C;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[i]     = 16'h1111 * 16'(i + 1);
      ref_mem[i] = mem[i];
    end
    vecs[0] = '{16'h0000, 16'h1111};
    vecs[1] = '{16'h0001, 16'h2222};
    vecs[2] = '{16'h0002, 16'h3333};
    vecs[3] = '{16'h0003, 16'h4444};

    fetch_addr = '0;
    st_req     = 1'b0;
    st_addr    = '0;
    st_data    = '0;

    // Reset state, including a request held during reset.
    repeat (2) @(negedge pci_clk);
    st_req = 1'b1;
    #1;
    check("rst_fetch_instr", 32'(fetch_instr), 32'd0);
    check("rst_st_busy", 32'(st_busy), 32'd0);
    check("rst_we_n", 32'(ram2_we_n), 32'd1);
    check("rst_oe_n", 32'(ram2_oe_n), 32'd0);
    check("rst_en_n", 32'(ram2_en_n), 32'd0);
    check("rst_bus_released", 32'(dut.bus_drive), 32'd0);
    st_req = 1'b0;
    @(negedge pci_clk);
    pci_rst = 1'b1;

    // Table: consecutive fetches, each word one cycle after its address.
    for (int i = 0; i < 4; i++) begin
      fetch_addr = vecs[i].addr;
      #1;
      check($sformatf("tbl_before_edge[%0d]", i), 32'(fetch_instr),
            (i == 0) ? 32'd0 : 32'(vecs[i-1].exp));
      tick();
      check($sformatf("tbl_fetch[%0d]", i), 32'(fetch_instr), 32'(vecs[i].exp));
    end

    // Random fetches against the reference memory.
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      fetch_check("rand_fetch", a);
    end

`ifdef RAM2_WRITE_EN
    // Single store, then read back.
    store_burst("st1", 1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000);
    fetch_check("st1_readback", 16'h0010);

    // Back-to-back stores with st_req held across the return to IDLE.
    store_burst("b2b", 2, 16'h0020, 16'h1234, 16'h0021, 16'h5678);
    fetch_check("b2b_readback0", 16'h0020);
    fetch_check("b2b_readback1", 16'h0021);

    // Random mix of stores and fetches over a small address window.
    for (int i = 0; i < 16; i++) begin
      a = 16'h0100 + 16'($urandom_range(0, 14));
      if ($urandom_range(0, 2) == 0)
        store_burst("rand_st", int'($urandom_range(1, 2)), a, 16'($urandom),
                    a + 16'd1, 16'($urandom));
      else
        fetch_check("rand_mix_fetch", a);
    end

    // Reset in the middle of the write pulse aborts the write.
    w0      = writes_done;
    st_req  = 1'b1;
    st_addr = 16'h0030;
    st_data = 16'hCAFE;
    tick();
    st_req = 1'b0;
    budget = 0;
    while (ram2_we_n && budget < 10) begin
      tick();
      budget++;
    end
    check("rstp_in_pulse", 32'(ram2_we_n), 32'd0);
    #2;
    pci_rst = 1'b0;
    #1;
    check("rstp_we_n_high", 32'(ram2_we_n), 32'd1);
    check("rstp_bus_released", 32'(dut.bus_drive), 32'd0);
    check("rstp_st_busy", 32'(st_busy), 32'd0);
    check("rstp_oe_n", 32'(ram2_oe_n), 32'd0);
    tick();
    pci_rst = 1'b1;
    check("rstp_fetch_cleared", 32'(fetch_instr), 32'd0);
    check("rstp_no_write", 32'(writes_done - w0), 32'd0);
    fetch_check("rstp_readback", 16'h0030);
`else
    // Read-only build: store requests are ignored, fetch never stalls.
    st_req  = 1'b1;
    st_addr = 16'h0040;
    st_data = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      a = 16'h0200 + 16'(i);
      fetch_addr = a;
      #1;
      check("ro_st_busy", 32'(st_busy), 32'd0);
      check("ro_we_n", 32'(ram2_we_n), 32'd1);
      tick();
      check("ro_fetch", 32'(fetch_instr), 32'(ref_mem[a]));
    end
    st_req = 1'b0;
    check("ro_no_write", 32'(writes_done), 32'd0);
    fetch_check("ro_readback", 16'h0040);
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
